// File: rtl/mac_vetor_param_pkg.sv
// Shared types and helpers for the parametrised multiply-accumulate engine.
// Holds the controller state encoding and the counter-width helper.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Smallest r such that 2**r >= value; used for clog2(LEN+1) counter widths.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_vetor_param_mult_reg_stage.sv
// Registered multiplier stage: captures m*p on load and flags it valid for
// exactly the following cycle so the accumulator adds each product once.
module mult_reg_stage #(
    parameter int W_IN = 10
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                load,
    input  logic [W_IN-1:0]     m,
    input  logic [W_IN-1:0]     p,
    output logic [2*W_IN-1:0]   prod_q,
    output logic                prod_v_q
);

    logic [2*W_IN-1:0] prod_d;
    logic              prod_v_d;

    // Next product and its valid flag.
    always_comb begin
        prod_d   = prod_q;
        prod_v_d = 1'b0;
        if (load) begin
            prod_d   = {{W_IN{1'b0}}, m} * {{W_IN{1'b0}}, p};
            prod_v_d = 1'b1;
        end else begin
            prod_d   = prod_q;
            prod_v_d = 1'b0;
        end
    end

    // Product registers with synchronous reset.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            prod_q   <= {(2*W_IN){1'b0}};
            prod_v_q <= 1'b0;
        end else begin
            prod_q   <= prod_d;
            prod_v_q <= prod_v_d;
        end
    end

endmodule

// File: rtl/mac_vetor_param.sv
// Dot-product MAC: streams LEN unsigned m/p pairs under valid/ready, adds the
// registered products into a W_ACC accumulator with saturate-or-wrap overflow.
module mac_vetor_param
    import mac_pkg::*;
#(
    parameter int W_IN  = 10,
    parameter int LEN   = 4,
    parameter int W_ACC = 22,
    parameter int SAT   = 1
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               start,
    input  logic               in_valid,
    input  logic [W_IN-1:0]    m,
    input  logic [W_IN-1:0]    p,
    output logic               in_ready,
    output logic [W_ACC-1:0]   o,
    output logic               out_valid,
    output logic               overflow,
    output logic               busy
);

    localparam int CNT_W = clog2(LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);
    localparam int PAD_W = W_ACC + 1 - 2 * W_IN;

    if (W_ACC < 2 * W_IN) begin : g_width_check
        $error("mac_vetor_param: W_ACC must be at least 2*W_IN");
    end
    if (LEN < 1) begin : g_len_check
        $error("mac_vetor_param: LEN must be at least 1");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [W_ACC-1:0]   acc_q, acc_d;
    logic               overflow_q, overflow_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;

    logic               accept_s;
    logic [2*W_IN-1:0]  prod_s;
    logic               prod_v_s;
    logic [W_ACC:0]     sum_s;

    assign accept_s = in_valid & in_ready_q;
    // Product is zero-extended so the carry out of the add lands in sum_s[W_ACC].
    assign sum_s    = {1'b0, acc_q} + {{PAD_W{1'b0}}, prod_s};

    mult_reg_stage #(
        .W_IN (W_IN)
    ) u_mult (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .load     (accept_s),
        .m        (m),
        .p        (p),
        .prod_q   (prod_s),
        .prod_v_q (prod_v_s)
    );

    // Controller next-state, accumulator update and registered output values.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        overflow_d = overflow_q;

        if (prod_v_s) begin
            if (sum_s[W_ACC]) begin
                overflow_d = 1'b1;
                acc_d      = (SAT != 0) ? {W_ACC{1'b1}} : sum_s[W_ACC-1:0];
            end else begin
                acc_d      = sum_s[W_ACC-1:0];
            end
        end else begin
            acc_d = acc_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ACCUM;
                    acc_d      = {W_ACC{1'b0}};
                    overflow_d = 1'b0;
                    count_d    = {CNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (accept_s) begin
                    count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (count_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = ACCUM;
                end
            end
            // Leave once the last product has been folded into the accumulator.
            DRAIN: begin
                if (!prod_v_s) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == ACCUM);
        busy_d      = (state_d == ACCUM) || (state_d == DRAIN);
        out_valid_d = (state_d == DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= IDLE;
            count_q     <= {CNT_W{1'b0}};
            acc_q       <= {W_ACC{1'b0}};
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign o         = acc_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mac_vetor_param.sv
// Self-checking bench: three MAC configurations share one stimulus stream and
// are compared every cycle against a transaction-level dot-product model.
module tb_mac_vetor_param;

    localparam int LEN = 4;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [9:0]  m = 10'd0;
    logic [9:0]  p = 10'd0;

    logic [2:0]  ir, ovl, ofl, bz;
    logic [21:0] o_0;
    logic [19:0] o_1, o_2;
    logic [63:0] oo [3];

    int total = 0;
    int bad   = 0;

    always #5 CLOCK = ~CLOCK;

    mac_vetor_param #(.W_IN(10), .LEN(LEN), .W_ACC(22), .SAT(1)) u_dut0 (
        .CLOCK(CLOCK), .RESET(RESET), .start(start), .in_valid(in_valid), .m(m), .p(p),
        .in_ready(ir[0]), .o(o_0), .out_valid(ovl[0]), .overflow(ofl[0]), .busy(bz[0]));
    mac_vetor_param #(.W_IN(10), .LEN(LEN), .W_ACC(20), .SAT(1)) u_dut1 (
        .CLOCK(CLOCK), .RESET(RESET), .start(start), .in_valid(in_valid), .m(m), .p(p),
        .in_ready(ir[1]), .o(o_1), .out_valid(ovl[1]), .overflow(ofl[1]), .busy(bz[1]));
    mac_vetor_param #(.W_IN(10), .LEN(LEN), .W_ACC(20), .SAT(0)) u_dut2 (
        .CLOCK(CLOCK), .RESET(RESET), .start(start), .in_valid(in_valid), .m(m), .p(p),
        .in_ready(ir[2]), .o(o_2), .out_valid(ovl[2]), .overflow(ofl[2]), .busy(bz[2]));

    assign oo[0] = {42'd0, o_0};
    assign oo[1] = {44'd0, o_1};
    assign oo[2] = {44'd0, o_2};

    // Model: edge index, vector progress and one accumulator per configuration.
    int     k = 0;
    bit     active = 1'b0;
    int     n_acc = 0;
    int     t_last = -100;
    longint pend = 0;
    bit     pend_v = 1'b0;
    longint acc_m [3] = '{0, 0, 0};
    bit     ovf_m [3] = '{1'b0, 1'b0, 1'b0};
    int     wacc  [3] = '{22, 20, 20};
    bit     sat_m [3] = '{1'b1, 1'b1, 1'b0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        longint s, lim;
        k++;
        if (RESET) begin
            active = 1'b0; n_acc = 0; t_last = -100; pend_v = 1'b0;
            for (int c = 0; c < 3; c++) begin
                acc_m[c] = 0; ovf_m[c] = 1'b0;
            end
        end else begin
            if (pend_v) begin
                for (int c = 0; c < 3; c++) begin
                    lim = 64'sd1 << wacc[c];
                    s = acc_m[c] + pend;
                    if (s >= lim) begin
                        ovf_m[c] = 1'b1;
                        acc_m[c] = sat_m[c] ? lim - 1 : s - lim;
                    end else begin
                        acc_m[c] = s;
                    end
                end
                pend_v = 1'b0;
            end
            if (active) begin
                if (in_valid) begin
                    pend = longint'(m) * longint'(p);
                    pend_v = 1'b1;
                    n_acc++;
                    if (n_acc == LEN) begin
                        active = 1'b0;
                        t_last = k;
                    end
                end
            end else if (start && k >= t_last + 4) begin
                active = 1'b1; n_acc = 0;
                for (int c = 0; c < 3; c++) begin
                    acc_m[c] = 0; ovf_m[c] = 1'b0;
                end
            end
        end
    endtask

    always @(posedge CLOCK) model_step();

    // Every cycle, all outputs of all configurations against the model.
    always @(negedge CLOCK) begin
        if (k > 0) begin
            for (int c = 0; c < 3; c++) begin
                check($sformatf("o[%0d]", c), oo[c], 64'(acc_m[c]));
                check($sformatf("overflow[%0d]", c), 64'(ofl[c]), 64'(ovf_m[c]));
                check($sformatf("in_ready[%0d]", c), 64'(ir[c]), 64'(active));
                check($sformatf("busy[%0d]", c), 64'(bz[c]), 64'(active || (k <= t_last + 1)));
                check($sformatf("out_valid[%0d]", c), 64'(ovl[c]), 64'(k == t_last + 2));
            end
        end
    end

    task automatic tick();
        @(posedge CLOCK);
        #2;
    endtask

    // Run one vector with per-pair idle gaps, then pin the final outputs to literals.
    task automatic run_vec(input int a[4], input int b[4], input int gap[4], input int start_at,
                           input bit junk, input longint e0, input longint e1, input longint e2,
                           input bit f0, input bit f1, input bit f2);
        bit found;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < LEN; i++) begin
            in_valid = 1'b0;
            repeat (gap[i]) tick();
            in_valid = 1'b1;
            m = 10'(a[i]);
            p = 10'(b[i]);
            start = (i == start_at);
            tick();
            start = 1'b0;
        end
        in_valid = junk;
        m = 10'd1023;
        p = 10'd1023;
        found = 1'b0;
        for (int c = 0; c < 8 && !found; c++) begin
            tick();
            if (ovl[0]) found = 1'b1;
        end
        if (found) begin
            check("final_o0", 64'(o_0), 64'(e0));
            check("final_o1", 64'(o_1), 64'(e1));
            check("final_o2", 64'(o_2), 64'(e2));
            check("final_ovf", {61'd0, ofl}, {61'd0, f2, f1, f0});
        end else begin
            check("out_valid_timeout", 64'd0, 64'd1);
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        repeat (3) tick();
        RESET = 1'b0;
        tick();

        run_vec('{3, 4, 5, 6}, '{6, 7, 8, 9}, '{0, 0, 0, 0}, -1, 1'b0, 140, 140, 140, 1'b0, 1'b0, 1'b0);
        run_vec('{1023, 1023, 1023, 1023}, '{1023, 1023, 1023, 1023}, '{0, 0, 0, 0}, -1, 1'b0,
                4186116, 1048575, 1040388, 1'b0, 1'b1, 1'b1);
        run_vec('{2, 3, 1, 0}, '{2, 3, 5, 9}, '{0, 2, 1, 0}, -1, 1'b1, 18, 18, 18, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a vector, then a clean vector with a stray start.
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; m = 10'd3; p = 10'd6;
        repeat (2) tick();
        in_valid = 1'b0;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("rst_o0", 64'(o_0), 64'd0);
        check("rst_busy", {61'd0, bz}, 64'd0);
        check("rst_ready", {61'd0, ir}, 64'd0);
        run_vec('{3, 3, 3, 3}, '{6, 6, 6, 6}, '{0, 0, 0, 0}, 1, 1'b0, 72, 72, 72, 1'b0, 1'b0, 1'b0);

        // Random traffic, including stray starts, gaps and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            RESET    = ($urandom_range(0, 199) == 0);
            start    = ($urandom_range(0, 3) == 0);
            in_valid = $urandom_range(0, 1) == 1;
            m = ($urandom_range(0, 2) == 0) ? 10'd1023 : 10'($urandom_range(0, 1023));
            p = ($urandom_range(0, 2) == 0) ? 10'd1023 : 10'($urandom_range(0, 1023));
            tick();
        end
        RESET = 1'b0; start = 1'b0; in_valid = 1'b0;
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
